hdc_ctrl_regs: RTL and testbench

Parametrised AXI4-Lite control/status register file for the HDC encoder datapath, replacing hard-wired n-gram length, dimension-block count and item-memory size with software-programmable registers. Drives `matw`/`run`/`last` to the stream controllers and cores. Owns the item-memory write address counter with automatic `matw` clear. Adds status readback, SLVERR on unmapped addresses, byte strobes and optional performance counters.

---
 rtl/hdc_ctrl_regs_pkg.sv | 44 ++++
 rtl/hdc_ctrl_regs_if.sv | 32 +++
 rtl/hdc_ctrl_regs_axil_slave_fsm.sv | 87 ++++++++
 rtl/hdc_ctrl_regs.sv | 199 +++++++++++++++++++
 tb/tb_hdc_ctrl_regs.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hdc_ctrl_regs_pkg.sv
// Shared definitions for the HDC encoder control/status register file:
// register offsets, CTRL/STATUS bit positions, reset values and the AXI-Lite bus FSM states.
package hdc_pkg;

    localparam logic [7:0] HDC_REG_CTRL    = 8'h00;
    localparam logic [7:0] HDC_REG_STATUS  = 8'h04;
    localparam logic [7:0] HDC_REG_NGRAM   = 8'h08;
    localparam logic [7:0] HDC_REG_DIMBLK  = 8'h0C;
    localparam logic [7:0] HDC_REG_SCRATCH = 8'h10;
    localparam logic [7:0] HDC_REG_ITEMNUM = 8'h14;
    localparam logic [7:0] HDC_REG_CYCLES  = 8'h18;
    localparam logic [7:0] HDC_REG_BLOCKS  = 8'h1C;

    localparam int HDC_CTRL_MATW = 0;
    localparam int HDC_CTRL_RUN  = 1;
    localparam int HDC_CTRL_LAST = 2;

    localparam int HDC_STAT_MATW = 0;
    localparam int HDC_STAT_RUN  = 1;
    localparam int HDC_STAT_BUSY = 2;
    localparam int HDC_STAT_DONE = 3;

    localparam int HDC_NGRAM_RST   = 2;
    localparam int HDC_DIMBLK_RST  = 7;
    localparam int HDC_ITEMNUM_RST = 99;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, AW, W, AWW, AR1, AR2} axil_state_t;

    // Byte k of the result comes from new_val when strb[k] is set, otherwise from old_val.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) r[8*k +: 8] = new_val[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/hdc_ctrl_regs_if.sv
// AXI4-Lite bus bundle for the HDC control register file; master drives requests, slave responds.
interface hdc_ctrl_regs_if #(parameter int ADDR_W = 12);

    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/hdc_ctrl_regs_axil_slave_fsm.sv
// AXI4-Lite handshake FSM with address/data capture; emits a one-shot register write
// strobe on entry to AWW and a read strobe in AR1.
module axil_slave_fsm
    import hdc_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic              rvalid,
    input  logic              rready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic [3:0]        wr_strb,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr
);

    axil_state_t state, next_state;
    logic        wr_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (awvalid && wvalid) next_state = AWW;
                else if (awvalid)      next_state = AW;
                else if (wvalid)       next_state = W;
                else if (arvalid)      next_state = AR1;
            end
            AW:      if (wvalid)  next_state = AWW;
            W:       if (awvalid) next_state = AWW;
            AWW:     if (bready)  next_state = IDLE;
            AR1:                  next_state = AR2;
            AR2:     if (rready)  next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    always_comb begin
        awready = (state == IDLE) || (state == W);
        wready  = (state == IDLE) || (state == AW);
        arready = (state == IDLE);
        bvalid  = (state == AWW);
        rvalid  = (state == AR2);
        wr_en   = wr_pend && (state == AWW);
        rd_en   = (state == AR1);
    end

    // A read is only accepted from IDLE when no write channel is competing for the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_strb <= '0;
            rd_addr <= '0;
        end else begin
            wr_pend <= (state != AWW) && (next_state == AWW);
            if (awready && awvalid) wr_addr <= awaddr;
            if (wready && wvalid) begin
                wr_data <= wdata;
                wr_strb <= wstrb;
            end
            if ((state == IDLE) && arvalid && !awvalid && !wvalid) rd_addr <= araddr;
        end
    end

endmodule

// File: rtl/hdc_ctrl_regs.sv
// HDC encoder control/status register file on AXI4-Lite, with item-memory address counter.
// Define HDC_PERF_CNT_EN to build the CYCLES/BLOCKS performance counters.
module hdc_ctrl_regs
    import hdc_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int NGRAM_W = 20,
    parameter int ITEM_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    hdc_ctrl_regs_if.slave     bus,
    input  logic               item_wr,
    input  logic               blk_done,
    output logic               matw,
    output logic               run,
    output logic               last,
    output logic [NGRAM_W-1:0] ngram_n,
    output logic [NGRAM_W-1:0] dim_blocks,
    output logic [ITEM_W-1:0]  item_num,
    output logic [ITEM_W-1:0]  item_addr
);

    localparam logic [2:0] IDX_CTRL    = HDC_REG_CTRL[4:2];
    localparam logic [2:0] IDX_STATUS  = HDC_REG_STATUS[4:2];
    localparam logic [2:0] IDX_NGRAM   = HDC_REG_NGRAM[4:2];
    localparam logic [2:0] IDX_DIMBLK  = HDC_REG_DIMBLK[4:2];
    localparam logic [2:0] IDX_SCRATCH = HDC_REG_SCRATCH[4:2];
    localparam logic [2:0] IDX_ITEMNUM = HDC_REG_ITEMNUM[4:2];
    localparam logic [2:0] IDX_CYCLES  = HDC_REG_CYCLES[4:2];
    localparam logic [2:0] IDX_BLOCKS  = HDC_REG_BLOCKS[4:2];

    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
        .clk     (clk),
        .rst     (rst),
        .awaddr  (bus.awaddr),
        .awvalid (bus.awvalid),
        .awready (bus.awready),
        .wdata   (bus.wdata),
        .wstrb   (bus.wstrb),
        .wvalid  (bus.wvalid),
        .wready  (bus.wready),
        .bvalid  (bus.bvalid),
        .bready  (bus.bready),
        .araddr  (bus.araddr),
        .arvalid (bus.arvalid),
        .arready (bus.arready),
        .rvalid  (bus.rvalid),
        .rready  (bus.rready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_strb (wr_strb),
        .rd_en   (rd_en),
        .rd_addr (rd_addr)
    );

    logic        done;
    logic [31:0] scratch;
    logic [31:0] cycles_val, blocks_val;
    logic [31:0] ctrl_word, status_word;
    logic [31:0] wr_old, wr_merged, rd_val;
    logic        wr_mapped, rd_mapped;
    logic [2:0]  wr_idx, rd_idx;
    logic        ctrl_wr, ngram_wr, dimblk_wr, scratch_wr, itemnum_wr;
    logic        start_run, auto_clr;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^{wr_addr[1:0], rd_addr[1:0]};

    assign wr_mapped = (wr_addr[ADDR_W-1:5] == '0);
    assign wr_idx    = wr_addr[4:2];
    assign rd_mapped = (rd_addr[ADDR_W-1:5] == '0);
    assign rd_idx    = rd_addr[4:2];

    assign ctrl_word   = {29'd0, last, run, matw};
    assign status_word = {28'd0, done, run & ~done, run, matw};

    // Byte strobes merge into the current register value before truncation to field width.
    always_comb begin
        wr_old = '0;
        case (wr_idx)
            IDX_CTRL:    wr_old = ctrl_word;
            IDX_NGRAM:   wr_old = 32'(ngram_n);
            IDX_DIMBLK:  wr_old = 32'(dim_blocks);
            IDX_SCRATCH: wr_old = scratch;
            IDX_ITEMNUM: wr_old = 32'(item_num);
            default:     wr_old = '0;
        endcase
    end

    assign wr_merged  = strb_merge(wr_old, wr_data, wr_strb);
    assign ctrl_wr    = wr_en && wr_mapped && (wr_idx == IDX_CTRL);
    assign ngram_wr   = wr_en && wr_mapped && (wr_idx == IDX_NGRAM);
    assign dimblk_wr  = wr_en && wr_mapped && (wr_idx == IDX_DIMBLK);
    assign scratch_wr = wr_en && wr_mapped && (wr_idx == IDX_SCRATCH);
    assign itemnum_wr = wr_en && wr_mapped && (wr_idx == IDX_ITEMNUM);
    assign start_run  = ctrl_wr && wr_merged[HDC_CTRL_RUN];
    assign auto_clr   = matw && item_wr && (item_addr == item_num);

    assign bus.bresp = wr_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;

    // A software CTRL write overrides the automatic matw clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            matw <= 1'b0;
            run  <= 1'b0;
            last <= 1'b0;
        end else if (ctrl_wr) begin
            matw <= wr_merged[HDC_CTRL_MATW];
            run  <= wr_merged[HDC_CTRL_RUN];
            last <= wr_merged[HDC_CTRL_LAST];
        end else if (auto_clr) begin
            matw <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ngram_n    <= NGRAM_W'(HDC_NGRAM_RST);
            dim_blocks <= NGRAM_W'(HDC_DIMBLK_RST);
            item_num   <= ITEM_W'(HDC_ITEMNUM_RST);
            scratch    <= '0;
        end else begin
            if (ngram_wr)   ngram_n    <= wr_merged[NGRAM_W-1:0];
            if (dimblk_wr)  dim_blocks <= wr_merged[NGRAM_W-1:0];
            if (itemnum_wr) item_num   <= wr_merged[ITEM_W-1:0];
            if (scratch_wr) scratch    <= wr_merged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          item_addr <= '0;
        else if (!matw)   item_addr <= '0;
        else if (item_wr) item_addr <= auto_clr ? '0 : item_addr + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   done <= 1'b0;
        else if (start_run)        done <= 1'b0;
        else if (blk_done && last) done <= 1'b1;
    end

`ifdef HDC_PERF_CNT_EN
    logic [31:0] cycles_q, blocks_q;

    // CYCLES saturates so long runs never appear shorter; BLOCKS simply wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycles_q <= '0;
            blocks_q <= '0;
        end else if (start_run) begin
            cycles_q <= '0;
            blocks_q <= '0;
        end else begin
            if (run && (cycles_q != 32'hFFFF_FFFF)) cycles_q <= cycles_q + 32'd1;
            if (blk_done) blocks_q <= blocks_q + 32'd1;
        end
    end

    assign cycles_val = cycles_q;
    assign blocks_val = blocks_q;
`else
    assign cycles_val = '0;
    assign blocks_val = '0;
`endif

    always_comb begin
        rd_val = '0;
        case (rd_idx)
            IDX_CTRL:    rd_val = ctrl_word;
            IDX_STATUS:  rd_val = status_word;
            IDX_NGRAM:   rd_val = 32'(ngram_n);
            IDX_DIMBLK:  rd_val = 32'(dim_blocks);
            IDX_SCRATCH: rd_val = scratch;
            IDX_ITEMNUM: rd_val = 32'(item_num);
            IDX_CYCLES:  rd_val = cycles_val;
            IDX_BLOCKS:  rd_val = blocks_val;
            default:     rd_val = '0;
        endcase
    end

    // Read data is captured once in AR1 and held until the master takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata <= '0;
            bus.rresp <= AXI_RESP_OKAY;
        end else if (rd_en) begin
            bus.rdata <= rd_mapped ? rd_val : 32'd0;
            bus.rresp <= rd_mapped ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

endmodule

// File: tb/tb_hdc_ctrl_regs.sv
// Directed self-checking bench for hdc_ctrl_regs; optional counter checks follow HDC_PERF_CNT_EN.
module tb_hdc_ctrl_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        item_wr, blk_done;
    logic        matw, run, last;
    logic [19:0] ngram_n, dim_blocks;
    logic [15:0] item_num, item_addr;
    int          n_checks = 0;
    int          n_fail   = 0;

    hdc_ctrl_regs_if #(.ADDR_W(12)) bus ();

    hdc_ctrl_regs #(.ADDR_W(12), .NGRAM_W(20), .ITEM_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .item_wr    (item_wr),
        .blk_done   (blk_done),
        .matw       (matw),
        .run        (run),
        .last       (last),
        .ngram_n    (ngram_n),
        .dim_blocks (dim_blocks),
        .item_num   (item_num),
        .item_addr  (item_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int t;
        @(negedge clk);
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1; bus.bready = 1'b1;
        t = 0;
        while (!(bus.awready && bus.wready) && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        t = 0;
        while (!bus.bvalid && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (bus.bvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL write_bvalid_timeout addr=%h got=%b expected=1", addr, bus.bvalid);
        end
        resp = bus.bresp;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int t;
        @(negedge clk);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        t = 0;
        while (!bus.arready && t < 20) begin @(negedge clk); t++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        t = 0;
        while (!bus.rvalid && t < 20) begin @(negedge clk); t++; end
        n_checks++;
        if (bus.rvalid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL read_rvalid_timeout addr=%h got=%b expected=1", addr, bus.rvalid);
        end
        data = bus.rdata;
        resp = bus.rresp;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic [11:0] addrs [4];
        logic [31:0] exp_d [4];
        addrs = '{12'h008, 12'h00C, 12'h014, 12'h000};
        exp_d = '{32'd2, 32'd7, 32'd99, 32'd0};
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({matw, run, last} !== 3'b000 || item_addr !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_ctrl got matw/run/last=%b item_addr=%0d expected 000 and 0",
                     {matw, run, last}, item_addr);
        end
        n_checks++;
        if (ngram_n !== 20'd2 || dim_blocks !== 20'd7 || item_num !== 16'd99) begin
            n_fail++;
            $display("[TB] FAIL reset_cfg got ngram=%0d dimblk=%0d itemnum=%0d expected 2 7 99",
                     ngram_n, dim_blocks, item_num);
        end
        n_checks++;
        if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
            n_fail++;
            $display("[TB] FAIL reset_handshake got aw/w/ar_ready,b/r_valid=%b expected 11100",
                     {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], d, r);
            n_checks++;
            if (d !== exp_d[i] || r !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL reset_read addr=%h got data=%h resp=%b expected data=%h resp=00",
                         addrs[i], d, r, exp_d[i]);
            end
        end
    endtask

    task automatic test_item_counter();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h014, 32'd3, 4'hF, r);
        n_checks++;
        if (item_num !== 16'd3) begin
            n_fail++;
            $display("[TB] FAIL itemnum_write got=%0d expected=3", item_num);
        end
        axi_write(12'h000, 32'd1, 4'hF, r);
        n_checks++;
        if (matw !== 1'b1 || item_addr !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL matw_set got matw=%b addr=%0d expected 1 and 0", matw, item_addr);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (item_addr !== 16'(i) || matw !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL item_step%0d got addr=%0d matw=%b expected addr=%0d matw=1",
                         i, item_addr, matw, i);
            end
            item_wr = 1'b1;
            @(negedge clk);
        end
        item_wr = 1'b0;
        n_checks++;
        if (matw !== 1'b0 || item_addr !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL matw_autoclear got matw=%b addr=%0d expected 0 and 0", matw, item_addr);
        end
        axi_read(12'h004, d, r);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL status_after_clear got=%h expected=00000000", d);
        end
        // item_num = 0: the very first item write ends the load
        axi_write(12'h014, 32'd0, 4'hF, r);
        axi_write(12'h000, 32'd1, 4'hF, r);
        item_wr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (matw !== 1'b0 || item_addr !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL itemnum0_clear got matw=%b addr=%0d expected 0 and 0", matw, item_addr);
        end
        @(negedge clk);
        item_wr = 1'b0;
        n_checks++;
        if (item_addr !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL addr_hold_matw0 got=%0d expected=0", item_addr);
        end
    endtask

    task automatic test_simultaneous_clear();
        logic [1:0] r;
        axi_write(12'h000, 32'd1, 4'hF, r);
        @(negedge clk);
        bus.awaddr = 12'h000; bus.awvalid = 1'b1;
        bus.wdata = 32'd1; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        item_wr = 1'b1;
        @(negedge clk);
        item_wr = 1'b0;
        bus.bready = 1'b0;
        n_checks++;
        if (matw !== 1'b1 || item_addr !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL sw_wins_autoclear got matw=%b addr=%0d expected 1 and 0", matw, item_addr);
        end
        axi_write(12'h000, 32'd0, 4'hF, r);
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h008, 32'hAABBCCDD, 4'b0001, r);
        axi_read(12'h008, d, r);
        n_checks++;
        if (d !== 32'h000000DD || r !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL ngram_strb0001 got data=%h resp=%b expected 000000dd 00", d, r);
        end
        axi_write(12'h008, 32'hFFFFFFFF, 4'hF, r);
        axi_read(12'h008, d, r);
        n_checks++;
        if (d !== 32'h000FFFFF || ngram_n !== 20'hFFFFF) begin
            n_fail++;
            $display("[TB] FAIL ngram_width_mask got data=%h port=%h expected 000fffff fffff", d, ngram_n);
        end
        axi_write(12'h010, 32'h11223344, 4'b0110, r);
        axi_read(12'h010, d, r);
        n_checks++;
        if (d !== 32'h00223300) begin
            n_fail++;
            $display("[TB] FAIL scratch_strb0110 got=%h expected=00223300", d);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d;
        logic [1:0]  r;
        logic [11:0] addr;
        logic [31:0] val;
        int          bcount;
        for (int pass = 0; pass < 2; pass++) begin
            addr = (pass == 0) ? 12'h010 : 12'h00C;
            val  = (pass == 0) ? 32'h5A5A5A5A : 32'd5;
            @(negedge clk);
            bus.bready = 1'b0;
            bus.awaddr = addr; bus.wdata = val; bus.wstrb = 4'hF;
            if (pass == 0) bus.awvalid = 1'b1; else bus.wvalid = 1'b1;
            @(negedge clk);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            repeat (2) @(negedge clk);
            if (pass == 0) bus.wvalid = 1'b1; else bus.awvalid = 1'b1;
            @(negedge clk);
            bus.awvalid = 1'b0; bus.wvalid = 1'b0;
            repeat (2) @(negedge clk);
            n_checks++;
            if (bus.bvalid !== 1'b1 || bus.bresp !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL split_bvalid pass=%0d got bvalid=%b bresp=%b expected 1 00",
                         pass, bus.bvalid, bus.bresp);
            end
            bus.bready = 1'b1;
            @(negedge clk);
            bus.bready = 1'b0;
            bcount = 0;
            for (int c = 0; c < 5; c++) begin
                if (bus.bvalid === 1'b1) bcount++;
                @(negedge clk);
            end
            n_checks++;
            if (bcount !== 0) begin
                n_fail++;
                $display("[TB] FAIL split_single_bvalid pass=%0d got extra=%0d expected=0", pass, bcount);
            end
            axi_read(addr, d, r);
            n_checks++;
            if (d !== val) begin
                n_fail++;
                $display("[TB] FAIL split_data pass=%0d got=%h expected=%h", pass, d, val);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h040, 32'hDEADBEEF, 4'hF, r);
        n_checks++;
        if (r !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL unmapped_bresp got=%b expected=10", r);
        end
        axi_read(12'h000, d, r);
        n_checks++;
        if (d !== 32'd0 || {matw, run, last} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL unmapped_no_alias got ctrl=%h expected=00000000", d);
        end
        axi_read(12'h010, d, r);
        n_checks++;
        if (d !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("[TB] FAIL unmapped_scratch_kept got=%h expected=5a5a5a5a", d);
        end
        axi_read(12'h040, d, r);
        n_checks++;
        if (d !== 32'd0 || r !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL unmapped_read40 got data=%h resp=%b expected 00000000 10", d, r);
        end
        axi_read(12'h020, d, r);
        n_checks++;
        if (r !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL unmapped_read20 got resp=%b expected=10", r);
        end
    endtask

    task automatic test_run_done();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(12'h000, 32'd6, 4'hF, r);
        axi_read(12'h004, d, r);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("[TB] FAIL status_busy got=%h expected=00000006", d);
        end
        repeat (10) @(negedge clk);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        axi_read(12'h004, d, r);
        n_checks++;
        if (d !== 32'hA) begin
            n_fail++;
            $display("[TB] FAIL status_done got=%h expected=0000000a", d);
        end
`ifdef HDC_PERF_CNT_EN
        axi_read(12'h018, d, r);
        n_checks++;
        if (d < 32'd10 || d > 32'd40 || r !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL perf_cycles got=%0d resp=%b expected 10..40 and 00", d, r);
        end
        axi_read(12'h01C, d, r);
        n_checks++;
        if (d !== 32'd1 || r !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL perf_blocks got=%0d resp=%b expected 1 and 00", d, r);
        end
`else
        axi_read(12'h018, d, r);
        n_checks++;
        if (d !== 32'd0 || r !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL cycles_disabled got=%h resp=%b expected 00000000 00", d, r);
        end
        axi_read(12'h01C, d, r);
        n_checks++;
        if (d !== 32'd0 || r !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL blocks_disabled got=%h resp=%b expected 00000000 00", d, r);
        end
`endif
        axi_write(12'h000, 32'd4, 4'hF, r);
        axi_read(12'h004, d, r);
        n_checks++;
        if (d !== 32'h8) begin
            n_fail++;
            $display("[TB] FAIL status_run0_done got=%h expected=00000008", d);
        end
        axi_write(12'h000, 32'd2, 4'hF, r);
        blk_done = 1'b1;
        @(negedge clk);
        blk_done = 1'b0;
        axi_read(12'h004, d, r);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++;
            $display("[TB] FAIL status_done_cleared got=%h expected=00000006", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        int          vcount;
        @(negedge clk);
        bus.araddr = 12'h008; bus.arvalid = 1'b1; bus.rready = 1'b0;
        @(negedge clk);
        bus.arvalid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.rvalid === 1'b1) vcount++;
            @(negedge clk);
        end
        n_checks++;
        if (vcount !== 0 || bus.arready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_rvalid got rvalid_cycles=%0d arready=%b expected 0 and 1",
                     vcount, bus.arready);
        end
        n_checks++;
        if (ngram_n !== 20'd2 || dim_blocks !== 20'd7 || run !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_regs got ngram=%0d dimblk=%0d run=%b expected 2 7 0",
                     ngram_n, dim_blocks, run);
        end
        axi_read(12'h010, d, r);
        n_checks++;
        if (d !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_scratch got=%h expected=00000000", d);
        end
    endtask

    initial begin
        rst = 1'b1;
        item_wr = 1'b0;
        blk_done = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        test_reset();
        test_item_counter();
        test_simultaneous_clear();
        test_strobes();
        test_split_write();
        test_unmapped();
        test_run_done();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
